raster_scan_counter: RTL and testbench

RASTER_SCAN_COUNTER -- requirements
Module: raster_scan_counter

---
 rtl/raster_scan_counter_pkg.sv | 22 ++
 rtl/raster_scan_counter_step_divider.sv | 66 ++++++
 rtl/raster_scan_counter.sv | 127 ++++++++++++
 tb/tb_raster_scan_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/raster_scan_counter_pkg.sv
// ============================================================================
//  raster_scan_counter_pkg
//  Shared scan-state encoding and default frame geometry.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package raster_scan_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    localparam int DEF_H_SIZE = 160;
    localparam int DEF_V_SIZE = 120;
    localparam int DEF_ADDR_W = 15;

endpackage

`default_nettype wire

// File: rtl/raster_scan_counter_step_divider.sv
// ============================================================================
//  step_divider / dff_re
//  Step-rate divider and the reset/enable flop primitive it is built from.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dff_re #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

module step_divider #(
    parameter int DIV   = 1,
    parameter int DIV_W = 26
) (
    input  logic clk,
    input  logic scanReset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // The count only moves on enabled clocks, so a low enable freezes the phase.
    assign tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    dff_re #(.W(DIV_W)) u_cnt_reg (
        .clk   (clk),
        .rst_n (scanReset),
        .en_i  (1'b1),
        .d_i   (cnt_d),
        .q_o   (cnt_q)
    );

endmodule

`default_nettype wire

// File: rtl/raster_scan_counter.sv
// ============================================================================
//  raster_scan_counter
//  Walks x/y over an H_SIZE x V_SIZE frame with an incrementally kept address.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module raster_scan_counter
    import raster_scan_counter_pkg::*;
#(
    parameter int H_SIZE = DEF_H_SIZE,
    parameter int V_SIZE = DEF_V_SIZE,
    parameter int XW     = 8,
    parameter int YW     = 7,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV    = 1,
    parameter int DIV_W  = 26
) (
    input  logic              clk,
    input  logic              scanReset,
    input  logic              start,
    input  logic              continuous,
    input  logic              advance,
    input  logic              abort,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [XW-1:0] X_LAST = XW'(H_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_SIZE - 1);

    logic [1:0]        state_raw;
    scan_state_e       state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic              in_run, step, x_last, frame_last;

    assign state_q    = scan_state_e'(state_raw);
    assign in_run     = (state_q == ST_RUN);
    assign x_last     = (x_q == X_LAST);
    assign frame_last = x_last && (y_q == Y_LAST);

    step_divider #(.DIV(DIV), .DIV_W(DIV_W)) u_step_divider (
        .clk       (clk),
        .scanReset (scanReset),
        .clear     (abort || !in_run),
        .enable    (advance && in_run && !abort),
        .tick      (step)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
                ST_RUN:           if (step && frame_last && !mode_q) state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Position update; the last step either wraps (continuous) or freezes.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (abort) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            mode_d = 1'b0;
        end else if (!in_run) begin
            if (start) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
                mode_d = continuous;
            end
        end else if (step) begin
            if (frame_last) begin
                done_d = 1'b1;
                if (mode_q) begin
                    x_d    = '0;
                    y_d    = '0;
                    addr_d = '0;
                end
            end else if (x_last) begin
                x_d    = '0;
                y_d    = y_q + YW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                x_d    = x_q + XW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    dff_re #(.W(2))      u_state_reg (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(state_d), .q_o(state_raw));
    dff_re #(.W(XW))     u_x_reg     (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(x_d),     .q_o(x_q));
    dff_re #(.W(YW))     u_y_reg     (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(y_d),     .q_o(y_q));
    dff_re #(.W(ADDR_W)) u_addr_reg  (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(addr_d),  .q_o(addr_q));
    dff_re #(.W(1))      u_mode_reg  (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(mode_d),  .q_o(mode_q));
    dff_re #(.W(1))      u_done_reg  (.clk(clk), .rst_n(scanReset), .en_i(1'b1), .d_i(done_d),  .q_o(done_q));

    always_comb begin
        valid = in_run;
        busy  = in_run;
        x     = x_q;
        y     = y_q;
        addr  = addr_q;
        done  = done_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_raster_scan_counter.sv
// ============================================================================
//  tb_raster_scan_counter
//  Three geometries (4x3, 4x3 with DIV=3, 1x1) driven in parallel against a
//  linear-index reference model through an expected-value queue.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_raster_scan_counter;

    logic clk = 1'b0;
    logic scanReset = 1'b0;
    logic start = 1'b0, continuous = 1'b0, advance = 1'b0, abort = 1'b0;

    logic [1:0] xa, ya, xb, yb;
    logic [3:0] aa, ab_addr;
    logic       va, ba, da, vb, bb, db;
    logic       xc, yc, ac, vc, bc, dc;

    always #5 clk = ~clk;

    raster_scan_counter #(.H_SIZE(4), .V_SIZE(3), .XW(2), .YW(2), .ADDR_W(4), .DIV(1), .DIV_W(4)) u_a (
        .clk(clk), .scanReset(scanReset), .start(start), .continuous(continuous),
        .advance(advance), .abort(abort), .x(xa), .y(ya), .addr(aa),
        .valid(va), .busy(ba), .done(da));

    raster_scan_counter #(.H_SIZE(4), .V_SIZE(3), .XW(2), .YW(2), .ADDR_W(4), .DIV(3), .DIV_W(4)) u_b (
        .clk(clk), .scanReset(scanReset), .start(start), .continuous(continuous),
        .advance(advance), .abort(abort), .x(xb), .y(yb), .addr(ab_addr),
        .valid(vb), .busy(bb), .done(db));

    raster_scan_counter #(.H_SIZE(1), .V_SIZE(1), .XW(1), .YW(1), .ADDR_W(1), .DIV(1), .DIV_W(2)) u_c (
        .clk(clk), .scanReset(scanReset), .start(start), .continuous(continuous),
        .advance(advance), .abort(abort), .x(xc), .y(yc), .addr(ac),
        .valid(vc), .busy(bc), .done(dc));

    typedef struct {
        int inst;
        int x;
        int y;
        int addr;
        bit vld;
        bit dn;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0=IDLE 1=RUN 2=DONE, position kept as a linear index.
    int P_H[3] = '{4, 4, 1};
    int P_V[3] = '{3, 3, 1};
    int P_D[3] = '{1, 3, 1};
    int m_st[3], m_n[3], m_div[3], m_mode[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_n[i] = 0; m_div[i] = 0; m_mode[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic s, input logic c, input logic a, input logic ab);
        exp_t e;
        bit dn = 1'b0;
        if (ab) begin
            m_st[i] = 0; m_n[i] = 0; m_div[i] = 0; m_mode[i] = 0;
        end else if (m_st[i] != 1) begin
            if (s) begin
                m_st[i] = 1; m_n[i] = 0; m_div[i] = 0; m_mode[i] = int'(c);
            end
        end else if (a) begin
            if (m_div[i] == P_D[i] - 1) begin
                m_div[i] = 0;
                if (m_n[i] == P_H[i] * P_V[i] - 1) begin
                    dn = 1'b1;
                    if (m_mode[i] != 0) m_n[i] = 0;
                    else m_st[i] = 2;
                end else begin
                    m_n[i] = m_n[i] + 1;
                end
            end else begin
                m_div[i] = m_div[i] + 1;
            end
        end
        e.inst = i;
        e.x    = m_n[i] % P_H[i];
        e.y    = m_n[i] / P_H[i];
        e.addr = m_n[i];
        e.vld  = (m_st[i] == 1);
        e.dn   = dn;
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        logic [31:0] ox, oy, oa;
        logic        ov, ob, od;
        case (e.inst)
            0:       begin ox = 32'(xa); oy = 32'(ya); oa = 32'(aa);      ov = va; ob = ba; od = da; end
            1:       begin ox = 32'(xb); oy = 32'(yb); oa = 32'(ab_addr); ov = vb; ob = bb; od = db; end
            default: begin ox = 32'(xc); oy = 32'(yc); oa = 32'(ac);      ov = vc; ob = bc; od = dc; end
        endcase
        check($sformatf("inst%0d x", e.inst),     ox, e.x);
        check($sformatf("inst%0d y", e.inst),     oy, e.y);
        check($sformatf("inst%0d addr", e.inst),  oa, e.addr);
        check($sformatf("inst%0d valid", e.inst), 32'(ov), 32'(e.vld));
        check($sformatf("inst%0d busy", e.inst),  32'(ob), 32'(e.vld));
        check($sformatf("inst%0d done", e.inst),  32'(od), 32'(e.dn));
    endtask

    task automatic check_all_zero(input string tag);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.inst = i; e.x = 0; e.y = 0; e.addr = 0; e.vld = 1'b0; e.dn = 1'b0;
            compare(e);
        end
        check({tag, " sb_empty"}, 32'(sb.size()), 0);
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    task automatic cyc(input logic s, input logic c, input logic a, input logic ab);
        start = s; continuous = c; advance = a; abort = ab;
        for (int i = 0; i < 3; i++) model_step(i, s, c, a, ab);
        @(posedge clk);
        #1;
        while (sb.size() > 0) compare(sb.pop_front());
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        scanReset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // One-frame scan, including a start while running.
        cyc(1, 0, 1, 0);
        for (int k = 0; k < 16; k++) cyc(k == 4, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Continuous scan, 30 steps.
        cyc(0, 0, 0, 1);
        cyc(1, 1, 1, 0);
        for (int k = 0; k < 30; k++) cyc(k == 7, 0, 1, 0);

        // Advance gating with the divider.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 0);
        for (int k = 0; k < 30; k++) cyc(0, 0, (k % 3) != 1, 0);

        // Abort at (2,1) together with start and advance.
        cyc(0, 0, 0, 1);
        cyc(1, 1, 1, 0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0);
        cyc(1, 1, 1, 1);
        cyc(0, 0, 1, 0);

        // Asynchronous reset mid-run.
        cyc(1, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0);
        #2 scanReset = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        #2 scanReset = 1'b1;
        cyc(1, 0, 1, 0);
        for (int k = 0; k < 14; k++) cyc(0, 0, 1, 0);

        // Random traffic.
        for (int k = 0; k < 60; k++)
            cyc(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, ($urandom_range(0, 19) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
